// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID (pr1) register, fetches over a req/ack port.
// Optional perf counters (redirect_count, bubble_count) are enabled by defining FETCH_PERF_EN.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_IR   = 16'hE000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  pc_mux_select,
  input  logic [15:0] rb_data,
  input  logic [15:0] ld_data,
  input  logic [15:0] jal_target,
  input  logic [15:0] beq_target,
  input  logic [15:0] lhi_data,
  input  logic [15:0] alu_data,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] pc,
  output logic [15:0] pr1_IR,
  output logic [15:0] pr1_PC,
  output logic        pr1_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] redirect_count,
  output logic [15:0] bubble_count
`endif
);

  typedef enum logic [1:0] {StStart, StFetch, StHold, StDrop} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pr1_ir_q, pr1_ir_d;
  logic [15:0] pr1_pc_q, pr1_pc_d;
  logic        pr1_valid_q, pr1_valid_d;
  logic [15:0] buf_q, buf_d;
  logic [15:0] drop_addr_q, drop_addr_d;

  logic        redirect;
  logic [15:0] target;
  logic        load_bubble;
  logic        load_word;
  logic [15:0] word;

  always_comb begin
    redirect = 1'b0;
    target   = pc_q;
    unique case (pc_mux_select)
      3'd1: begin redirect = 1'b1; target = rb_data;    end
      3'd2: begin redirect = 1'b1; target = ld_data;    end
      3'd3: begin redirect = 1'b1; target = jal_target; end
      3'd4: begin redirect = 1'b1; target = beq_target; end
      3'd5: begin redirect = 1'b1; target = lhi_data;   end
      3'd6: begin redirect = 1'b1; target = alu_data;   end
      default: begin redirect = 1'b0; target = pc_q;    end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pr1_ir_d    = pr1_ir_q;
    pr1_pc_d    = pr1_pc_q;
    pr1_valid_d = pr1_valid_q;
    buf_d       = buf_q;
    drop_addr_d = drop_addr_q;
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    load_bubble = 1'b0;
    load_word   = 1'b0;
    word        = imem_rdata;

    unique case (state_q)
      StStart: begin
        state_d = StFetch;
        if (redirect) begin
          pc_d        = target;
          load_bubble = 1'b1;
        end
      end
      StFetch: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_d        = target;
          load_bubble = 1'b1;
          // Request still outstanding: keep presenting it until the memory retires it.
          if (!imem_ack) begin
            state_d     = StDrop;
            drop_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          if (stall) begin
            buf_d   = imem_rdata;
            state_d = StHold;
          end else begin
            load_word = 1'b1;
          end
        end else if (!stall) begin
          load_bubble = 1'b1;
        end
      end
      StHold: begin
        word = buf_q;
        if (redirect) begin
          pc_d        = target;
          load_bubble = 1'b1;
          state_d     = StFetch;
        end else if (!stall) begin
          load_word = 1'b1;
          state_d   = StFetch;
        end
      end
      StDrop: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
        if (redirect) begin
          pc_d        = target;
          load_bubble = 1'b1;
        end else if (!stall) begin
          load_bubble = 1'b1;
        end
        if (imem_ack) begin
          state_d = StFetch;
        end
      end
      default: state_d = StStart;
    endcase

    if (load_bubble) begin
      pr1_ir_d    = NOP_IR;
      pr1_valid_d = 1'b0;
    end else if (load_word) begin
      pr1_ir_d    = word;
      pr1_pc_d    = pc_q;
      pr1_valid_d = 1'b1;
      pc_d        = pc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StStart;
      pc_q        <= RESET_PC;
      pr1_ir_q    <= NOP_IR;
      pr1_pc_q    <= 16'h0000;
      pr1_valid_q <= 1'b0;
      buf_q       <= 16'h0000;
      drop_addr_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pr1_ir_q    <= pr1_ir_d;
      pr1_pc_q    <= pr1_pc_d;
      pr1_valid_q <= pr1_valid_d;
      buf_q       <= buf_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  assign pc        = pc_q;
  assign pr1_IR    = pr1_ir_q;
  assign pr1_PC    = pr1_pc_q;
  assign pr1_valid = pr1_valid_q;

`ifdef FETCH_PERF_EN
  logic [15:0] redirect_count_q, redirect_count_d;
  logic [15:0] bubble_count_q, bubble_count_d;

  always_comb begin
    redirect_count_d = redirect_count_q;
    bubble_count_d   = bubble_count_q;
    if (redirect && (redirect_count_q != 16'hFFFF)) begin
      redirect_count_d = redirect_count_q + 16'd1;
    end
    if (load_bubble && (bubble_count_q != 16'hFFFF)) begin
      bubble_count_d = bubble_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_count_q <= 16'h0000;
      bubble_count_q   <= 16'h0000;
    end else begin
      redirect_count_q <= redirect_count_d;
      bubble_count_q   <= bubble_count_d;
    end
  end

  assign redirect_count = redirect_count_q;
  assign bubble_count   = bubble_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a
// flag-based behavioural model and a variable-latency memory model.
module tb_fetch_stage;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] NOP_IR   = 16'hE000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  pc_mux_select;
  logic [15:0] rb_data, ld_data, jal_target, beq_target, lhi_data, alu_data;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] pc, pr1_IR, pr1_PC;
  logic        pr1_valid;
`ifdef FETCH_PERF_EN
  logic [15:0] redirect_count, bubble_count;
`endif

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_IR   (NOP_IR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_mux_select (pc_mux_select),
    .rb_data       (rb_data),
    .ld_data       (ld_data),
    .jal_target    (jal_target),
    .beq_target    (beq_target),
    .lhi_data      (lhi_data),
    .alu_data      (alu_data),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .pr1_IR        (pr1_IR),
    .pr1_PC        (pr1_PC),
    .pr1_valid     (pr1_valid)
`ifdef FETCH_PERF_EN
    ,
    .redirect_count (redirect_count),
    .bubble_count   (bubble_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a fetch pipeline described by "started", "word buffered" and
  // "aborted request outstanding" flags rather than an explicit state machine.
  bit          m_started, m_have_buf, m_stale, m_valid;
  logic [15:0] m_pc, m_ir, m_ppc, m_buf, m_stale_addr;
  int          m_rc, m_bc;
  bit          mem_busy;
  int          mem_wait;

  task automatic model_reset();
    m_started  = 0;
    m_have_buf = 0;
    m_stale    = 0;
    m_valid    = 0;
    m_pc       = RESET_PC;
    m_ir       = NOP_IR;
    m_ppc      = 16'h0000;
    m_buf      = 16'h0000;
    m_rc       = 0;
    m_bc       = 0;
    mem_busy   = 0;
    mem_wait   = 0;
  endtask

  task automatic model_bubble();
    m_ir    = NOP_IR;
    m_valid = 0;
    if (m_bc < 65535) m_bc++;
  endtask

  task automatic model_deliver(input logic [15:0] w);
    m_ir    = w;
    m_ppc   = m_pc;
    m_valid = 1;
    m_pc    = m_pc + 16'd1;
  endtask

  task automatic model_step(input logic [2:0] sel, input logic [15:0] tgt, input bit st,
                            input bit ack, input logic [15:0] rd);
    bit redir;
    redir = (sel >= 3'd1) && (sel <= 3'd6);
    if (redir && m_rc < 65535) m_rc++;
    if (!m_started) begin
      m_started = 1;
      if (redir) begin m_pc = tgt; model_bubble(); end
    end else if (m_stale) begin
      if (redir) begin m_pc = tgt; model_bubble(); end
      else if (!st) model_bubble();
      if (ack) m_stale = 0;
    end else if (m_have_buf) begin
      if (redir) begin m_pc = tgt; model_bubble(); m_have_buf = 0; end
      else if (!st) begin model_deliver(m_buf); m_have_buf = 0; end
    end else begin
      if (redir) begin
        if (!ack) begin m_stale = 1; m_stale_addr = m_pc; end
        m_pc = tgt;
        model_bubble();
      end else if (ack) begin
        if (st) begin m_buf = rd; m_have_buf = 1; end
        else model_deliver(rd);
      end else if (!st) model_bubble();
    end
  endtask

  task automatic compare_outputs();
    bit exp_req;
    exp_req = m_started && !m_have_buf;
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
    check("pc", pc, m_pc);
    check("pr1_IR", pr1_IR, m_ir);
    check("pr1_PC", pr1_PC, m_ppc);
    check("pr1_valid", pr1_valid, m_valid);
`ifdef FETCH_PERF_EN
    check("redirect_count", redirect_count, m_rc[15:0]);
    check("bubble_count", bubble_count, m_bc[15:0]);
`endif
  endtask

  function automatic logic [15:0] sel_target(input logic [2:0] sel);
    case (sel)
      3'd1:    return rb_data;
      3'd2:    return ld_data;
      3'd3:    return jal_target;
      3'd4:    return beq_target;
      3'd5:    return lhi_data;
      3'd6:    return alu_data;
      default: return 16'h0000;
    endcase
  endfunction

  // One clock: compare at negedge, drive inputs, let the DUT clock, then advance the model.
  task automatic cycle(input logic [2:0] sel, input bit st, input int lat_lo, input int lat_hi);
    bit ack;
    @(negedge clk);
    compare_outputs();
    pc_mux_select = sel;
    stall         = st;
    ack           = 0;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_wait = $urandom_range(lat_hi, lat_lo);
      end
      if (mem_wait == 0) begin
        ack      = 1;
        mem_busy = 0;
      end else begin
        mem_wait--;
      end
    end
    imem_ack   = ack;
    imem_rdata = ack ? (imem_addr ^ 16'h1234) : 16'($urandom);
    @(posedge clk);
    #1;
    model_step(sel, sel_target(sel), st, ack, imem_rdata);
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    compare_outputs();
    rst_n = 1'b1;
  endtask

  task automatic randomize_targets();
    rb_data    = 16'($urandom);
    ld_data    = 16'($urandom);
    jal_target = 16'($urandom);
    beq_target = 16'($urandom);
    lhi_data   = 16'($urandom);
    alu_data   = 16'($urandom);
  endtask

  initial begin
    logic [15:0] saved_ir, saved_pc, old_addr;
    int          r;
    logic [2:0]  sel;
    pc_mux_select = 3'd0;
    stall         = 1'b0;
    imem_rdata    = 16'h0000;
    randomize_targets();
    apply_reset();

    // Zero-wait streaming after reset.
    repeat (8) cycle(3'd0, 1'b0, 0, 0);
    check("stream_pr1_pc", pr1_PC, 16'd6);
    check("stream_pr1_ir", pr1_IR, 16'd6 ^ 16'h1234);
    check("stream_pc", pc, 16'd7);

    // Branch redirect mid-stream.
    beq_target = 16'h0040;
    cycle(3'd4, 1'b0, 0, 0);
    check("beq_addr", imem_addr, 16'h0040);
    check("beq_bubble_ir", pr1_IR, NOP_IR);
    check("beq_bubble_valid", pr1_valid, 1'b0);
    cycle(3'd0, 1'b0, 0, 0);
    check("beq_first_pc", pr1_PC, 16'h0040);
    repeat (2) cycle(3'd0, 1'b0, 0, 0);

    // Redirect while a 3-cycle request is outstanding.
    alu_data = 16'h0100;
    cycle(3'd0, 1'b0, 2, 2);
    old_addr = imem_addr;
    cycle(3'd6, 1'b0, 2, 2);
    check("drop_req", imem_req, 1'b1);
    check("drop_addr", imem_addr, old_addr);
    cycle(3'd0, 1'b0, 2, 2);
    check("drop_new_addr", imem_addr, 16'h0100);
    repeat (4) cycle(3'd0, 1'b0, 2, 2);
    repeat (2) cycle(3'd0, 1'b0, 0, 0);

    // Stall for 4 cycles while the ack arrives.
    saved_ir = pr1_IR;
    saved_pc = pc;
    repeat (4) begin
      cycle(3'd0, 1'b1, 0, 0);
      check("stall_pr1_hold", pr1_IR, saved_ir);
    end
    cycle(3'd0, 1'b0, 0, 0);
    check("stall_release_pr1_pc", pr1_PC, saved_pc);
    check("stall_release_ir", pr1_IR, saved_pc ^ 16'h1234);
    check("stall_release_pc", pc, saved_pc + 16'd1);

    // PC wrap and select code 7.
    alu_data = 16'hFFFF;
    cycle(3'd6, 1'b0, 0, 0);
    cycle(3'd0, 1'b0, 0, 0);
    check("wrap_addr", imem_addr, 16'h0000);
    cycle(3'd7, 1'b0, 0, 0);
    check("sel7_pr1_pc", pr1_PC, 16'h0000);
    check("sel7_pc", pc, 16'h0001);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      randomize_targets();
      r   = $urandom_range(9, 0);
      sel = (r < 6) ? 3'd0 : (r == 6) ? 3'd7 : 3'($urandom_range(6, 1));
      cycle(sel, ($urandom_range(3, 0) == 0), 0, 3);
    end

    // Asynchronous reset while in DROP.
    repeat (6) cycle(3'd0, 1'b0, 0, 0);
    rb_data = 16'h0200;
    cycle(3'd0, 1'b0, 4, 4);
    cycle(3'd1, 1'b0, 4, 4);
    cycle(3'd0, 1'b0, 4, 4);
    #2;
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    #1;
    check("arst_req", imem_req, 1'b0);
    check("arst_pc", pc, RESET_PC);
    check("arst_ir", pr1_IR, NOP_IR);
    check("arst_pr1_pc", pr1_PC, 16'h0000);
    check("arst_valid", pr1_valid, 1'b0);
    apply_reset();
    repeat (4) cycle(3'd0, 1'b0, 0, 0);
    check("restart_pr1_pc", pr1_PC, RESET_PC + 16'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
